// File: rtl/ransac_pkg.sv
// Shared RANSAC definitions: accumulator state encoding, default widths and
// the point-stream end marker.
package ransac_pkg;

  localparam int CNT_W_DEF = 16;
  localparam int ID_W_DEF  = 16;

  localparam logic [31:0] END_OF_STREAM = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ACCUM   = 2'b01,
    COMPARE = 2'b11,
    DONE    = 2'b10
  } acc_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: synchronous clear has priority over the increment,
// and the count sticks at all-ones rather than wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (!reset_n)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (en && (cnt != '1))
      cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/inlier_accumulator.sv
// Counts inliers for one candidate model and keeps the best model seen so far.
// Optional INLIER_EARLY_STOP_EN ends a model once CONSENSUS inliers are found.
module inlier_accumulator
  import ransac_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int ID_W  = ID_W_DEF
`ifdef INLIER_EARLY_STOP_EN
  ,
  parameter int CONSENSUS = 64
`endif
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear_best,
  input  logic             start_model,
  input  logic [ID_W-1:0]  model_id,
  input  logic             inlier_valid,
  input  logic             inlier_in,
  input  logic             end_model,
  output logic             busy,
  output logic [CNT_W-1:0] cur_count,
  output logic [CNT_W-1:0] best_count,
  output logic [ID_W-1:0]  best_id,
  output logic             best_valid,
`ifdef INLIER_EARLY_STOP_EN
  output logic             early_stop,
`endif
  output logic             result_valid
);

  acc_state_t      state;
  logic [ID_W-1:0] cur_id;
  logic            take_start;
  logic            cnt_en;
  logic            es_hit;

  // start_model is only honoured where a model may begin or be aborted
  assign take_start = start_model && ((state == IDLE) || (state == ACCUM));
  assign cnt_en     = (state == ACCUM) && !start_model && inlier_valid && inlier_in;
  assign busy       = (state == ACCUM) || (state == COMPARE);

`ifdef INLIER_EARLY_STOP_EN
  // Unreachable thresholds (beyond saturation) simply never fire
  localparam bit ES_REACHABLE = (CONSENSUS >= 1) && (CONSENSUS <= (2**CNT_W - 1));
  logic [CNT_W:0] cnt_next;
  assign cnt_next = {1'b0, cur_count} + (CNT_W+1)'(1);
  assign es_hit   = ES_REACHABLE && cnt_en && (cnt_next == (CNT_W+1)'(CONSENSUS));
`else
  assign es_hit   = 1'b0;
`endif

  sat_counter #(.W(CNT_W)) u_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (take_start),
    .en      (cnt_en),
    .cnt     (cur_count)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= IDLE;
      cur_id       <= '0;
      best_count   <= '0;
      best_id      <= '0;
      best_valid   <= 1'b0;
      result_valid <= 1'b0;
`ifdef INLIER_EARLY_STOP_EN
      early_stop   <= 1'b0;
`endif
    end else begin
      result_valid <= 1'b0;
      case (state)
        IDLE: if (start_model) begin
          cur_id <= model_id;
          state  <= ACCUM;
        end
        ACCUM: begin
          if (start_model) begin
            cur_id <= model_id;
          end else if (es_hit || end_model) begin
            state <= COMPARE;
`ifdef INLIER_EARLY_STOP_EN
            if (es_hit) early_stop <= 1'b1;
`endif
          end
        end
        COMPARE: begin
          // ties keep the earlier model
          if (!best_valid || (cur_count > best_count)) begin
            best_count <= cur_count;
            best_id    <= cur_id;
          end
          best_valid <= 1'b1;
          state      <= DONE;
        end
        DONE: begin
          result_valid <= 1'b1;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // a clear in COMPARE overrides the compare result above
      if (clear_best) begin
        best_count <= '0;
        best_id    <= '0;
        best_valid <= 1'b0;
      end
`ifdef INLIER_EARLY_STOP_EN
      if (clear_best || take_start) early_stop <= 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_inlier_accumulator.sv
// Scoreboard bench for inlier_accumulator; a CNT_W=4 copy covers saturation
// and, with INLIER_EARLY_STOP_EN, a CONSENSUS=4 copy covers early stop.
module tb_inlier_accumulator;

  localparam int CW = 16;
  localparam int IW = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          clear_best = 1'b0;
  logic          start_model = 1'b0;
  logic [IW-1:0] model_id = '0;
  logic          inlier_valid = 1'b0;
  logic          inlier_in = 1'b0;
  logic          end_model = 1'b0;

  logic          busy, best_valid, result_valid;
  logic [CW-1:0] cur_count, best_count;
  logic [IW-1:0] best_id;

  logic          d4_busy, d4_best_valid, d4_result_valid;
  logic [3:0]    d4_cur_count, d4_best_count;
  logic [IW-1:0] d4_best_id;

`ifdef INLIER_EARLY_STOP_EN
  logic          early_stop, d4_early_stop;
  logic          es_busy, es_best_valid, es_result_valid, es_early_stop;
  logic [CW-1:0] es_cur_count, es_best_count;
  logic [IW-1:0] es_best_id;
`endif

  inlier_accumulator #(.CNT_W(CW), .ID_W(IW)) dut (
    .clk(clk), .reset_n(reset_n), .clear_best(clear_best),
    .start_model(start_model), .model_id(model_id),
    .inlier_valid(inlier_valid), .inlier_in(inlier_in), .end_model(end_model),
    .busy(busy), .cur_count(cur_count), .best_count(best_count),
    .best_id(best_id), .best_valid(best_valid),
`ifdef INLIER_EARLY_STOP_EN
    .early_stop(early_stop),
`endif
    .result_valid(result_valid)
  );

  inlier_accumulator #(.CNT_W(4), .ID_W(IW)) dut4 (
    .clk(clk), .reset_n(reset_n), .clear_best(clear_best),
    .start_model(start_model), .model_id(model_id),
    .inlier_valid(inlier_valid), .inlier_in(inlier_in), .end_model(end_model),
    .busy(d4_busy), .cur_count(d4_cur_count), .best_count(d4_best_count),
    .best_id(d4_best_id), .best_valid(d4_best_valid),
`ifdef INLIER_EARLY_STOP_EN
    .early_stop(d4_early_stop),
`endif
    .result_valid(d4_result_valid)
  );

`ifdef INLIER_EARLY_STOP_EN
  inlier_accumulator #(.CNT_W(CW), .ID_W(IW), .CONSENSUS(4)) dut_es (
    .clk(clk), .reset_n(reset_n), .clear_best(clear_best),
    .start_model(start_model), .model_id(model_id),
    .inlier_valid(inlier_valid), .inlier_in(inlier_in), .end_model(end_model),
    .busy(es_busy), .cur_count(es_cur_count), .best_count(es_best_count),
    .best_id(es_best_id), .best_valid(es_best_valid),
    .early_stop(es_early_stop), .result_valid(es_result_valid)
  );

  int es_rv = 0;
  always @(negedge clk) if (es_result_valid) es_rv <= es_rv + 1;
`endif

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    int cnt;
    int bc;
    int bid;
    int bv;
    int due;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   m_cnt = 0, m_bc = 0, m_bid = 0, m_bv = 0, m_id = 0;

  task automatic chk(input string tag, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // result_valid must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (reset_n && result_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_result_valid", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        chk("rv_latency", cyc, mon_e.due);
        chk("rv_cur_count", cur_count, mon_e.cnt);
        chk("rv_best_count", best_count, mon_e.bc);
        chk("rv_best_id", best_id, mon_e.bid);
        chk("rv_best_valid", best_valid, mon_e.bv);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input int id);
    start_model = 1'b1;
    model_id    = IW'(id);
    m_cnt = 0;
    m_id  = id;
    tick();
    start_model = 1'b0;
  endtask

  task automatic pts(input int n, input bit v);
    repeat (n) begin
      inlier_valid = 1'b1;
      inlier_in    = v;
      if (v && m_cnt < 65535) m_cnt++;
      tick();
    end
    inlier_valid = 1'b0;
    inlier_in    = 1'b0;
  endtask

  task automatic wait_rv();
    for (int i = 0; i < 10 && sb.size() != 0; i++) tick();
    if (sb.size() != 0) begin
      chk("rv_timeout_pending", sb.size(), 0);
      sb.delete();
    end
  endtask

  task automatic endm(input bit with_pt, input bit clr_cmp);
    exp_t e;
    end_model = 1'b1;
    if (with_pt) begin
      inlier_valid = 1'b1;
      inlier_in    = 1'b1;
      if (m_cnt < 65535) m_cnt++;
    end
    if (clr_cmp) begin
      m_bc = 0; m_bid = 0; m_bv = 0;
    end else begin
      if (m_bv == 0 || m_cnt > m_bc) begin
        m_bc  = m_cnt;
        m_bid = m_id;
      end
      m_bv = 1;
    end
    e.cnt = m_cnt; e.bc = m_bc; e.bid = m_bid; e.bv = m_bv; e.due = cyc + 3;
    sb.push_back(e);
    tick();
    end_model    = 1'b0;
    inlier_valid = 1'b0;
    inlier_in    = 1'b0;
    if (clr_cmp) begin
      clear_best = 1'b1;
      tick();
      clear_best = 1'b0;
    end
    wait_rv();
  endtask

  task automatic clr_best();
    clear_best = 1'b1;
    tick();
    clear_best = 1'b0;
    m_bc = 0; m_bid = 0; m_bv = 0;
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_cur_count", cur_count, 0);
    chk("rst_best_valid", best_valid, 0);
    chk("rst_result_valid", result_valid, 0);
    reset_n = 1'b1;
    tick();

    // reset mid-ACCUM discards the partial model
    start(9);
    pts(5, 1);
    chk("t1_cur_count", cur_count, 5);
    chk("t1_busy", busy, 1);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("t1_rst_cur_count", cur_count, 0);
    chk("t1_rst_busy", busy, 0);
    chk("t1_rst_best_count", best_count, 0);
    chk("t1_rst_best_id", best_id, 0);
    chk("t1_rst_best_valid", best_valid, 0);
    pts(2, 1);
    end_model = 1'b1;
    tick();
    end_model = 1'b0;
    repeat (4) tick();
    chk("t1_idle_ignored", cur_count, 0);
    chk("t1_idle_busy", busy, 0);

    // basic model: points 1,0,1,1
    start(3);
    pts(1, 1); pts(1, 0); pts(2, 1);
    chk("t2_cur_count", cur_count, 3);
    endm(0, 0);
    chk("t2_hold_count", cur_count, 3);
    chk("t2_busy_idle", busy, 0);

    // tie keeps the earlier model
    clr_best();
    chk("t3_clr_valid", best_valid, 0);
    chk("t3_clr_count", best_count, 0);
    start(1); pts(4, 1); endm(0, 0);
    start(2); pts(2, 1); pts(1, 0); pts(2, 1); endm(0, 0);
    chk("t3_tie_id", best_id, 1);
    start(3); pts(7, 1); endm(0, 0);
    chk("t3_new_best_id", best_id, 3);
    chk("t3_new_best_cnt", best_count, 7);

    // saturation on the 4-bit copy, last point shares the end_model cycle
    start(5);
    pts(19, 1);
    chk("t4_sat_mid", d4_cur_count, 15);
    endm(1, 0);
    chk("t4_sat_final", d4_cur_count, 15);
    chk("t4_sat_best", d4_best_count, 15);
    chk("t4_wide_count", cur_count, 20);

    // abort in ACCUM, then clear during COMPARE
    start(6);
    pts(6, 1);
    chk("t5_pre_abort", cur_count, 6);
    start(7);
    chk("t5_abort_count", cur_count, 0);
    chk("t5_abort_busy", busy, 1);
    chk("t5_best_kept", best_count, 20);
    chk("t5_best_id_kept", best_id, 5);
    pts(2, 1);
    endm(0, 1);
    chk("t5_clr_valid", best_valid, 0);
    chk("t5_clr_count", best_count, 0);
    chk("t5_final_count", cur_count, 2);

`ifdef INLIER_EARLY_STOP_EN
    begin
      int rv0;
      clr_best();
      repeat (3) tick();
      rv0 = es_rv;
      start(11);
      for (int i = 1; i <= 10; i++) begin
        pts(1, 1);
        chk("t6_early_stop", es_early_stop, (i >= 4) ? 1 : 0);
      end
      endm(0, 0);
      repeat (3) tick();
      chk("t6_es_count", es_cur_count, 4);
      chk("t6_es_best", es_best_count, 4);
      chk("t6_es_best_id", es_best_id, 11);
      chk("t6_es_rv_pulses", es_rv - rv0, 1);
      chk("t6_es_held", es_early_stop, 1);
      clr_best();
      chk("t6_es_cleared", es_early_stop, 0);
    end
`endif

    repeat (3) tick();
    chk("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/inlier_accumulator.md
Name: inlier_accumulator

Overview:
Downstream stage of the inlier-checking function: consumes the per-point inlier flag stream for one candidate line model and counts inliers. At end of model, compares the count against the best model so far and keeps the best model ID and count. Software reads the results once all RANSAC iterations are done. It sits between the inlier checker output and the Nios register/readback path.

Parameters:
CNT_W, 16, inlier counter width (saturating)
ID_W, 16, model identifier width

Ports:
clk  in  1  system clock; all registers update on rising edge
reset_n  in  1  reset, synchronous, active-low
clear_best  in  1  pulse: forget best model (best_count=0, best_valid=0)
start_model  in  1  pulse: begin new model, latch model_id
model_id  in  ID_W  identifier of model being scored
inlier_valid  in  1  inlier_in is meaningful this cycle (one point)
inlier_in  in  1  1 = current point is an inlier
end_model  in  1  pulse: last point of current model delivered
busy  out  1  high in ACCUM/COMPARE
cur_count  out  CNT_W  running inlier count of current model
best_count  out  CNT_W  highest count seen since reset/clear_best
best_id  out  ID_W  model_id that produced best_count
best_valid  out  1  at least one model compared since reset/clear_best
result_valid  out  1  one-cycle pulse: compare finished

Behaviour:
- Reset (reset_n=0 at clk edge): state IDLE; every output and internal register is 0. Reset has priority over all inputs, including mid-ACCUM. The partial model is discarded.
- States: IDLE, ACCUM, COMPARE, DONE.
- IDLE: inlier_valid and end_model are ignored. start_model -> cur_count=0, latch model_id, go ACCUM.
- ACCUM:
  - inlier_valid&inlier_in increments cur_count, saturating at 2^CNT_W-1. Points with inlier_in=0 are ignored.
  - end_model -> COMPARE. A point with inlier_valid in the same cycle as end_model is counted.
  - start_model in ACCUM aborts the current model without comparing: cur_count=0, new model_id latched, stay ACCUM. start_model has priority over end_model.
- COMPARE (1 cycle): if !best_valid or cur_count > best_count (strict), load best_count=cur_count and best_id=latched id. Set best_valid=1. Go DONE.
  - Ties keep the earlier model.
  - A model with zero inliers still sets best_valid.
- DONE (1 cycle): result_valid=1, go IDLE. cur_count holds its final value until the next start_model.
- Latency: end_model at edge N -> best_* updated at edge N+1 -> result_valid high during cycle after edge N+2.
- busy is high in ACCUM and COMPARE, low in IDLE and DONE.
- clear_best is honoured in any state.
  - Outside COMPARE: zeroes best_count, best_id and best_valid.
  - During COMPARE: the clear wins and the compare result is dropped. result_valid still pulses.
- Inputs arriving in COMPARE/DONE (start_model, inlier_valid, end_model) are ignored. Upstream must not start a new model until result_valid has been seen.

Optional Feature:
INLIER_EARLY_STOP_EN:
- Adds parameter CONSENSUS (default 64) and output early_stop (1 bit).
- With the macro: in ACCUM, when cur_count reaches CONSENSUS, early_stop is asserted and held until the next start_model, clear_best or reset. Further points are ignored and the model is treated as ended (-> COMPARE), so software can terminate RANSAC.
- Without the macro: no port, no parameter, counting continues until end_model.

Decomposition:
- Shared package ransac_pkg holds:
  - state encoding constants (IDLE=2'b00, ACCUM=2'b01, COMPARE=2'b11, DONE=2'b10)
  - CNT_W/ID_W defaults
  - the end-of-stream marker 32'hFFFFFFFF used by the point stream
- One sub-module: sat_counter (enable, clear, saturating increment, width parameter).
- Compare/best-register logic stays in the top module.

Test Plan:
1. Reset mid-ACCUM after 5 inliers -> all outputs 0, state IDLE. Following inlier_valid is ignored.
2. Model id 3 with points 1,0,1,1 then end_model -> cur_count=3, best_count=3, best_id=3, best_valid=1. result_valid pulses exactly 2 cycles after end_model.
3. Models id 1 (4 inliers), id 2 (4 inliers), id 3 (7 inliers) -> after model 2, best_id=1 (tie kept). After model 3, best_id=3, best_count=7.
4. CNT_W=4, feed 20 inliers -> cur_count saturates at 15, no wrap. End_model in the same cycle as the last inlier still counts that point.
5. start_model during ACCUM at count 6 -> abort, no result_valid, best unchanged, count restarts at 0. clear_best pulsed during COMPARE -> best_valid=0, best_count=0.
6. With INLIER_EARLY_STOP_EN, CONSENSUS=4 and 10 inliers -> early_stop rises on the 4th inlier, best_count=4, result_valid pulses. Later points and end_model are ignored.
